uart_tx_fifo_drain: RTL

Transmit back-end of the UART command path. It pops bytes from the TX FIFO (the ALU/register read responses of the system controller) and serialises them onto the UART line as 8-bit LSB-first frames with optional parity. It drives `busy` back toward the controller/FIFO side. It has a single clock domain with a built-in baud divider.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_bit_timer.sv | 37 +++
 rtl/uart_tx_fifo_drain.sv | 133 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART transmit path.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  // Values for the parity-type select.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Transmit FSM states. The encoding is visible on the debug port.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Even parity is the XOR of the byte. Odd parity is its inverse.
  function automatic logic calc_parity(input logic [UART_DATA_WIDTH-1:0] data,
                                       input logic                       typ);
    return (^data) ^ (typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer. It counts CLKS_PER_BIT cycles while enabled and pulses
// bit_done on the last cycle of each period. It wraps to zero after that cycle,
// so each period starts again from zero. clr holds it at zero.
module uart_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear, or advance and wrap at the end of the period.
  always_comb begin
    cnt_d    = cnt_q;
    bit_done = en && (cnt_q == LAST);
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = bit_done ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmit back-end. It pops bytes from a first-word-fall-through FIFO
// and sends each one as a frame: start bit, 8 data bits LSB first, an optional
// parity bit, then a stop bit.
//
// Handshake: !EMPTY acts as valid and RD_DATA is the payload. The pop strobe
// RD_INC is asserted in the cycle the word is accepted. A word is accepted only
// in IDLE or on the last stop-bit cycle. RD_INC is never asserted while EMPTY=1
// or while RST is held low.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EMPTY,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  RD_INC,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic [2:0]            state_dbg
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0]         bit_idx_q, bit_idx_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  bit_done;
  logic                  load;

  // The timer runs in every bit state. Each state change happens on bit_done,
  // where the timer wraps to zero, so every state starts a fresh period.
  uart_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (CLK),
    .rst_n    (RST),
    .clr      (state_q == IDLE),
    .en       (state_q != IDLE),
    .bit_done (bit_done)
  );

  // Load event: accept the FIFO head when idle, or on the last stop-bit cycle.
  always_comb begin
    load = RST && !EMPTY &&
           ((state_q == IDLE) || ((state_q == STOP) && bit_done));
  end

  // Next-state logic, shifter, and line/busy values for the next cycle.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;

    if (load) begin
      state_d   = START;
      shreg_d   = RD_DATA;
      bit_idx_d = '0;
      par_en_d  = PAR_EN;
      par_bit_d = calc_parity(UART_DATA_WIDTH'(RD_DATA), PAR_TYP);
    end else begin
      case (state_q)
        IDLE:   state_d = IDLE;
        START:  if (bit_done) begin
                  state_d   = DATA;
                  bit_idx_d = '0;
                end
        DATA:   if (bit_done) begin
                  shreg_d = shreg_q >> 1;
                  if (bit_idx_q == LAST_IDX) begin
                    state_d = par_en_q ? PARITY : STOP;
                  end else begin
                    bit_idx_d = bit_idx_q + 1'b1;
                  end
                end
        PARITY: if (bit_done) state_d = STOP;
        STOP:   if (bit_done) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // The line and busy are registered from the next state, so they change
    // in the same cycle as the state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers. Reset returns the line to idle right away.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // Output mapping.
  always_comb begin
    RD_INC    = load;
    TX_OUT    = tx_q;
    busy      = busy_q;
    state_dbg = state_q;
  end

endmodule
